suma1_seq: RTL and testbench

Multi-cycle increment unit, the counterpart to the ALU's decrement-by-one operation. It selects operand a or b, then adds 1 once per clock for a requested number of steps. The result is returned through a valid/ready handshake with carry and zero flags. It sits beside the combinational ALU operation blocks as the first sequenced ALU operation.

---
 rtl/alu_pkg.sv | 16 +
 rtl/inc_step.sv | 19 +
 rtl/suma1_seq.sv | 105 ++++++++++
 tb/tb_suma1_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, flag bit positions and default widths.
package alu_pkg;

    localparam int ANCHO_DEF = 4;
    localparam int CW_DEF    = 4;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/inc_step.sv
// Combinational +1 step with carry-out of the all-ones case.
// SUMA1_SATURATE_EN: holds all-ones instead of wrapping to zero.
module inc_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         co
);

    assign co = &x;

`ifdef SUMA1_SATURATE_EN
    assign y = co ? x : x + W'(1);
`else
    assign y = x + W'(1);
`endif

endmodule

// File: rtl/suma1_seq.sv
// Multi-cycle increment sequencer: selects a or b, applies pasos +1 steps and returns the result with flags.
// Saturating steps instead of wrap-around when SUMA1_SATURATE_EN is defined (see inc_step).
module suma1_seq
    import alu_pkg::*;
#(
    parameter int ancho = ANCHO_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [ancho-1:0] a,
    input  logic [ancho-1:0] b,
    input  logic             aluflagin,
    input  logic [CW-1:0]    pasos,
    output logic [ancho-1:0] aluresult,
    output logic [1:0]       aluflags,
    output logic             res_valid,
    input  logic             res_ready
);

    state_t           state, state_nx;
    logic [ancho-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [ancho-1:0] res_q;
    logic [1:0]       flags_q;
    logic [ancho-1:0] step_sum;
    logic             step_co;
    logic [ancho-1:0] sel_op;
    logic             accept;
    logic             last_step;

    inc_step #(.W(ancho)) u_inc (
        .x  (acc),
        .y  (step_sum),
        .co (step_co)
    );

    assign sel_op    = aluflagin ? b : a;
    assign accept    = start_valid && start_ready;
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (pasos != '0) ? RUN : DONE;
            RUN:  if (last_step) state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == IDLE);
        res_valid   = (state == DONE);
    end

    // Result and flags are captured on the edge entering DONE, so they stay put through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= sel_op;
                        cnt   <= pasos;
                        carry <= 1'b0;
                        if (pasos == '0) begin
                            res_q               <= sel_op;
                            flags_q[FLAG_ZERO]  <= (sel_op == '0);
                            flags_q[FLAG_CARRY] <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc   <= step_sum;
                    cnt   <= cnt - CW'(1);
                    carry <= carry | step_co;
                    if (last_step) begin
                        res_q               <= step_sum;
                        flags_q[FLAG_ZERO]  <= (step_sum == '0);
                        flags_q[FLAG_CARRY] <= carry | step_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign aluresult = res_q;
    assign aluflags  = flags_q;

endmodule

// File: tb/tb_suma1_seq.sv
// Scoreboard bench for suma1_seq: directed cases then randomized operations against an arithmetic model.
// Define SUMA1_SATURATE_EN for both bench and RTL to check the saturating build.
module tb_suma1_seq;

    typedef struct {
        logic [3:0] res;
        logic [1:0] flg;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       aluflagin = 1'b0;
    logic [3:0] pasos = '0;
    logic [3:0] aluresult;
    logic [1:0] aluflags;
    logic       res_valid;
    logic       res_ready = 1'b1;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rrMode = 0;
    bit   prevValid = 1'b0;
    exp_t sb[$];

    suma1_seq #(.ancho(4), .CW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .aluflagin   (aluflagin),
        .pasos       (pasos),
        .aluresult   (aluresult),
        .aluflags    (aluflags),
        .res_valid   (res_valid),
        .res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, random backpressure, or fully stalled.
    always @(posedge clk) begin
        #1;
        case (rrMode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: the result is just op+pasos in plain integers, clipped or wrapped to 4 bits.
    function automatic exp_t model(input logic [3:0] op, input logic [3:0] p, input int acceptCyc);
        exp_t e;
        int   s;
        s = int'(op) + int'(p);
`ifdef SUMA1_SATURATE_EN
        e.res = (s > 15) ? 4'hF : 4'(s);
`else
        e.res = 4'(s % 16);
`endif
        e.flg[1] = (e.res == 4'h0);
        e.flg[0] = (s > 15);
        e.due    = acceptCyc + int'(p);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (res_valid) begin
                checkOutput("start_ready_while_done", int'(start_ready), 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got res_valid=1 with result %0d, required no result", aluresult);
                end else begin
                    if (!prevValid) checkOutput("latency_cycle", cyc, sb[0].due);
                    checkOutput("aluresult", int'(aluresult), int'(sb[0].res));
                    checkOutput("aluflags", int'(aluflags), int'(sb[0].flg));
                    if (res_ready) void'(sb.pop_front());
                end
            end
            prevValid = res_valid && !res_ready;
        end
    end

    // Called #1 after a rising edge; leaves the bench at the same phase.
    task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib,
                                 input logic isel, input logic [3:0] ip);
        int waitc = 0;
        while (!start_ready && waitc < 200) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!start_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL start_ready_timeout: got start_ready=0 after %0d cycles, required 1", waitc);
            return;
        end
        a = ia;
        b = ib;
        aluflagin = isel;
        pasos = ip;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        sb.push_back(model(isel ? ib : ia, ip, cyc));
        a = 4'($urandom);
        b = 4'($urandom);
        aluflagin = 1'($urandom);
        pasos = 4'($urandom);
    endtask

    task automatic waitDrain();
        int waitc = 0;
        while ((sb.size() != 0 || res_valid) && waitc < 500) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (sb.size() != 0 || res_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, required 0", sb.size());
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_res_valid"}, int'(res_valid), 0);
        checkOutput({tag, "_aluresult"}, int'(aluresult), 0);
        checkOutput({tag, "_aluflags"}, int'(aluflags), 0);
        checkOutput({tag, "_start_ready"}, int'(start_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, required completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        #2;
        checkResetOutputs("reset");
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases from the plan.
        applyStimulus(4'h3, 4'h9, 1'b0, 4'd2);
        waitDrain();
        checkOutput("idle_after_t1", int'(start_ready), 1);
        applyStimulus(4'h6, 4'hE, 1'b1, 4'd3);
        waitDrain();
        applyStimulus(4'h0, 4'h7, 1'b0, 4'd0);
        waitDrain();
        applyStimulus(4'h1, 4'h2, 1'b0, 4'd15);
        waitDrain();

        // Stalled consumer while new requests keep arriving.
        rrMode = 2;
        applyStimulus(4'h7, 4'h2, 1'b0, 4'd3);
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            a = 4'($urandom);
            b = 4'($urandom);
            aluflagin = 1'($urandom);
            pasos = 4'($urandom);
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        rrMode = 0;
        waitDrain();
        @(posedge clk);
        #1;
        checkOutput("idle_after_stall", int'(start_ready), 1);
        checkOutput("no_result_after_stall", int'(res_valid), 0);

        // Asynchronous reset in the middle of a long run.
        applyStimulus(4'h2, 4'h0, 1'b0, 4'd10);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrun_reset");
        sb.delete();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4'h4, 4'hC, 1'b1, 4'd5);
        waitDrain();

        // Randomized operations with random backpressure.
        rrMode = 1;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
        end
        rrMode = 0;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
